// File: rtl/wb_data_master.sv
// Wishbone classic-cycle initiator for the CPU data-memory port.
// Turns one CPU load/store request into one bus cycle and stalls the pipeline until ack.
// Optional watchdog: define WB_MASTER_TIMEOUT_EN to add the BUSY timeout counter and wb_tmo_o.
module wb_data_master #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
`ifdef WB_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cpu_ce_i,
  input  logic            cpu_we_i,
  input  logic [AW-1:0]   cpu_addr_i,
  input  logic [DW/8-1:0] cpu_sel_i,
  input  logic [DW-1:0]   cpu_data_i,
  input  logic            flush_i,
  output logic [DW-1:0]   cpu_data_o,
  output logic            stall_req_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [DW-1:0]   wb_dat_o,
`ifdef WB_MASTER_TIMEOUT_EN
  output logic            wb_tmo_o,
`endif
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q;
  logic   flush_pend_q;
  logic   ack_ok;
  logic   flush_seen;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 10) ? $clog2(TIMEOUT_CYCLES) : 10;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_q;
  assign wb_tmo_o = tmo_q;
`endif

  // An ack only counts while our strobe is up; a flush this cycle or earlier discards the result
  assign ack_ok     = wb_ack_i & wb_stb_o;
  assign flush_seen = flush_pend_q | flush_i;

  // Stall is raised in the request cycle itself so the MEM stage holds; forced low in reset
  always_comb begin
    stall_req_o = 1'b0;
    unique case (state_q)
      S_IDLE:  stall_req_o = cpu_ce_i & ~flush_i;
      S_BUSY:  stall_req_o = 1'b1;
      default: stall_req_o = 1'b0;
    endcase
    if (!wb_rst_i) stall_req_o = 1'b0;
  end

  // Access sequencer: IDLE accepts, BUSY holds the bus until ack, DONE presents load data
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q      <= S_IDLE;
      flush_pend_q <= 1'b0;
      cpu_data_o   <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= '0;
      wb_dat_o     <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      tmo_q        <= 1'b0;
`endif
    end else begin
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_adr_o <= cpu_addr_i;
            wb_sel_o <= cpu_sel_i;
            wb_we_o  <= cpu_we_i;
            wb_dat_o <= cpu_data_i;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state_q  <= S_BUSY;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (ack_ok) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            flush_pend_q <= 1'b0;
            if (flush_seen) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DONE;
              if (!wb_we_o) cpu_data_o <= wb_dat_i;
            end
`ifdef WB_MASTER_TIMEOUT_EN
          end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Give up on a dead responder so the pipeline never hangs
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            flush_pend_q <= 1'b0;
            tmo_q        <= 1'b1;
            state_q      <= S_DONE;
            if (!wb_we_o) cpu_data_o <= DW'(32'hDEAD_BEEF);
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            if (flush_i) flush_pend_q <= 1'b1;
`else
          end else begin
            if (flush_i) flush_pend_q <= 1'b1;
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
